inst_fetch_stage: RTL and testbench
===================================

// Module: inst_fetch_stage
// PURPOSE
//  Fetch front end feeding the 32-bit-wide instruction RAM (sync read, 1-cycle latency).
//  Owns the PC and drives the RAM request port.
//  Buffers returned words with their PC in a 2-entry skid FIFO.
//  Presents {pc, inst} to decode over a valid/ready handshake.
//  Handles branch/exception redirects with a 1-cycle bubble and no stale words.
// PARAMETERS
//  RESET_PC    32'hbfc00000  first PC fetched after reset release
//  ADDR_WIDTH  18            RAM word-address width; addr = pc[ADDR_WIDTH+1:2]
//  SKID_DEPTH  2             FIFO entries; must be >= 2 for full throughput
// PORTS
//  clk             in   1           single clock, all state on rising edge
//  resetn          in   1           asynchronous, active-low reset
//  inst_sram_en    out  1           RAM read enable (one request per cycle)
//  inst_sram_wen   out  4           tied 4'b0 (fetch never writes)
//  inst_sram_addr  out  ADDR_WIDTH  RAM word address
//  inst_sram_wdata out  32          tied 32'b0
//  inst_sram_rdata in   32          RAM data, valid the cycle after en was high
//  redirect_valid  in   1           one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   32          new PC
//  if_valid        out  1           FIFO head valid to decode
//  id_ready        in   1           decode accepts head this cycle
//  if_pc           out  32          PC of head entry
//  if_inst         out  32          instruction of head entry
//  if_adel         out  1           head PC misaligned (pc[1:0]!=0); inst still the fetched word
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FIFO empty; if_valid=0, if_pc=0, if_inst=0, if_adel=0.
//   - fetch_pc=RESET_PC; inflight=0; inst_sram_en=0 while resetn=0.
//  Request issue:
//   - pop = if_valid & id_ready & ~redirect_valid.
//   - issue = (count + inflight - pop) < SKID_DEPTH, or redirect_valid.
//   - inst_sram_en = issue; addr from redirect_pc if redirect_valid, else fetch_pc.
//   - On issue: fetch_pc <= issued_pc + 4; inflight <= 1; req_pc <= issued_pc. Else inflight <= 0.
//  Response (cycle after issue):
//   - If inflight & ~redirect_valid: push {req_pc, inst_sram_rdata, req_pc[1:0]!=0}.
//   - Push and pop in the same cycle are both honoured; count unchanged.
//   - Overflow impossible by the issue rule; an assertion must check it.
//  Handshake:
//   - Head held stable while if_valid & ~id_ready.
//   - if_valid = (count != 0) & ~redirect_valid (combinational gate).
//   - Output order = fetch order.
//  Redirect (priority over everything):
//   - FIFO flushed at the edge; the response arriving in the redirect cycle is dropped.
//   - A request at redirect_pc is issued in the same cycle.
//   - First redirected word is visible on if_valid 2 cycles after the pulse.
//   - Back-to-back redirects: the latest wins; each drops the prior in-flight word.
//  Wrap-around: fetch_pc wraps 32'hffff_fffc -> 0; addr truncates (no error).
//  Async reset mid-operation: outputs and en go to reset values immediately;
//   an in-flight word is discarded.
//  Throughput: 1 instr/cycle when id_ready is held high.
// STRUCTURE
//  Shared header cpu_defines.vh:
//   - RESET_PC constant.
//   - fetch-entry field widths {pc[31:0], inst[31:0], adel}.
//  Sub-module fetch_skid_fifo:
//   - Parameterised depth, registered head, flush input, count output.
//   - Top level holds PC, request, inflight and redirect logic.
// TESTING
//  1 Release resetn, id_ready=1 -> en=1 addr=18'h0 first cycle, then 18'h1, 18'h2;
//    if_pc bfc00000, bfc00004 on consecutive cycles after 2-cycle start-up.
//  2 id_ready=0 for 10 cycles -> exactly 2 entries held, en drops, head stable;
//    release -> pcs bfc00000..bfc0000c in order, none lost or duplicated.
//  3 FIFO full, redirect_pc=bfc00100 -> if_valid=0 that cycle, addr=18'h40;
//    next valid head is pc bfc00100, old entries never appear.
//  4 redirect_valid and id_ready high together -> no pop counted, flush wins.
//    Redirects on 2 consecutive cycles (A, then B) -> only B stream appears.
//  5 redirect_pc=bfc00102 -> head pc bfc00102 with if_adel=1, inst = word at addr 18'h40.
//  6 resetn pulled low mid-stream with en high -> if_valid=0 and en=0 asynchronously;
//    after release fetch restarts at bfc00000.

Source files
------------

// File: rtl/inst_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch front end.
//   RESET_PC_DEFAULT : first PC fetched after reset release
//   fetch_entry_t    : one buffered fetch result {pc, inst, adel}
//   pc_misaligned    : address-error test on the low PC bits
package inst_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam int unsigned PC_W             = 32;
  localparam int unsigned INST_W           = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              adel;
  } fetch_entry_t;

  // A fetch address is word aligned only when its two low bits are zero.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_stage_skid_fifo.sv
// Small FIFO holding fetched words until decode accepts them.
//   clk, resetn : clock, async active-low reset
//   flush       : discard all entries (wins over push and pop)
//   push/data   : enqueue one fetch entry
//   pop         : dequeue the head entry
//   head        : current head entry, read from the storage registers
//   count       : number of valid entries
module inst_fetch_stage_skid_fifo
  import inst_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointer increment that also works for non power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The issue throttle upstream must never let a push land on a full FIFO.
  overflow_a: assert property (@(posedge clk) disable iff (!resetn)
    (do_push && !do_pop) |-> (count < CNT_W'(DEPTH)));

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction fetch front end: owns the PC, requests words from a
// synchronous-read instruction RAM (1-cycle latency), buffers results with
// their PC and hands {pc, inst, adel} to decode over valid/ready.
//   clk, resetn       : clock, async active-low reset
//   inst_sram_*       : RAM request port (read only, wen/wdata tied low)
//   redirect_valid/pc : one-cycle pulse restarting fetch at redirect_pc
//   if_valid/id_ready : handshake to decode
//   if_pc/inst/adel   : head entry; adel flags a misaligned PC
module inst_fetch_stage
  import inst_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  inst_sram_en,
  output logic [3:0]            inst_sram_wen,
  output logic [ADDR_WIDTH-1:0] inst_sram_addr,
  output logic [31:0]           inst_sram_wdata,
  input  logic [31:0]           inst_sram_rdata,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  if_valid,
  input  logic                  id_ready,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_inst,
  output logic                  if_adel
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic [31:0]      issue_pc;
  logic             inflight;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occupancy;
  logic             unused_pc_bits;
  fetch_entry_t     push_data;
  fetch_entry_t     head;

  // Slots already claimed: buffered words plus the one in flight, minus the
  // one decode takes this cycle. pop implies count >= 1, so no underflow.
  assign pop       = if_valid & id_ready & ~redirect_valid;
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue     = redirect_valid | (occupancy < OCC_W'(SKID_DEPTH));
  assign issue_pc  = redirect_valid ? redirect_pc : fetch_pc;

  // RAM request port; enable is forced low while reset is asserted.
  assign inst_sram_en    = resetn & issue;
  assign inst_sram_addr  = issue_pc[ADDR_WIDTH+1:2];
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;
  assign unused_pc_bits  = ^issue_pc;

  // PC and in-flight tracking; a redirect restarts the sequence.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= issue_pc + 32'd4;
        req_pc   <= issue_pc;
      end
    end
  end

  // A word returning in a redirect cycle belongs to the old stream: drop it.
  assign push           = inflight & ~redirect_valid;
  assign push_data.pc   = req_pc;
  assign push_data.inst = inst_sram_rdata;
  assign push_data.adel = pc_misaligned(req_pc[1:0]);

  inst_fetch_stage_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .CNT_W (CNT_W)
  ) u_skid_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Decode never sees a head during a redirect cycle.
  assign if_valid = (count != '0) & ~redirect_valid;
  assign if_pc    = head.pc;
  assign if_inst  = head.inst;
  assign if_adel  = head.adel;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage with a behavioural instruction
// RAM and a scoreboard of expected {pc, inst, adel} in fetch order.
module tb_inst_fetch_stage;

  localparam int unsigned AW       = 18;
  localparam logic [31:0] RST_PC   = 32'hbfc0_0000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_sram_en;
  logic [3:0]    inst_sram_wen;
  logic [AW-1:0] inst_sram_addr;
  logic [31:0]   inst_sram_wdata;
  logic [31:0]   inst_sram_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          if_valid;
  logic          id_ready;
  logic [31:0]   if_pc;
  logic [31:0]   if_inst;
  logic          if_adel;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_pop   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] sb_next;
  logic [31:0] mon_exp;
  logic [31:0] rnd_pc;

  always #5 clk = ~clk;

  inst_fetch_stage #(
    .RESET_PC   (RST_PC),
    .ADDR_WIDTH (AW),
    .SKID_DEPTH (2)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .id_ready        (id_ready),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_adel         (if_adel)
  );

  // Distinct, address-derived RAM contents.
  function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
    return {a, a[13:0]} ^ 32'h5a00_00c3;
  endfunction

  // Synchronous-read RAM: data the cycle after enable.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= ram_word(inst_sram_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(sb_next);
      sb_next = sb_next + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    sb_next = pc;
    sb_fill();
  endtask

  task automatic tick();
    @(negedge clk);
    sb_fill();
  endtask

  task automatic start_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    sb_restart(pc);
  endtask

  // Every accepted head must be the next expected entry.
  always @(negedge clk) begin
    #2;
    if (resetn && if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underrun", 32'(if_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        n_pop++;
        check("sb_pc", if_pc, mon_exp);
        check("sb_inst", if_inst, ram_word(mon_exp[AW+1:2]));
        check("sb_adel", 32'(if_adel), 32'(mon_exp[1:0] != 2'b00));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    sb_restart(RST_PC);
    repeat (3) tick();
    #1;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_inst", if_inst, 32'd0);
    check("rst_adel", 32'(if_adel), 32'd0);
    check("rst_en", 32'(inst_sram_en), 32'd0);
    check("wen_tied", 32'(inst_sram_wen), 32'd0);
    check("wdata_tied", inst_sram_wdata, 32'd0);

    // Start-up: addr 0,1,2 then heads on consecutive cycles.
    tick();
    resetn   = 1'b1;
    id_ready = 1'b1;
    #1;
    check("t1_en0", 32'(inst_sram_en), 32'd1);
    check("t1_addr0", 32'(inst_sram_addr), 32'h0);
    tick(); #1;
    check("t1_addr1", 32'(inst_sram_addr), 32'h1);
    check("t1_nvalid", 32'(if_valid), 32'd0);
    tick(); #1;
    check("t1_addr2", 32'(inst_sram_addr), 32'h2);
    check("t1_valid", 32'(if_valid), 32'd1);
    check("t1_pc0", if_pc, RST_PC);
    tick(); #1;
    check("t1_pc1", if_pc, RST_PC + 32'd4);
    repeat (4) tick();

    // Stall straight out of reset: two entries held, fetch stops.
    resetn   = 1'b0;
    id_ready = 1'b0;
    sb_restart(RST_PC);
    tick(); tick();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      if (i >= 1) begin
        check("t2_en_off", 32'(inst_sram_en), 32'd0);
        check("t2_valid", 32'(if_valid), 32'd1);
        check("t2_head", if_pc, RST_PC);
      end
    end
    tick();
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_stream_valid", 32'(if_valid), 32'd1);
      check("t2_stream_pc", if_pc, RST_PC + 32'(k) * 32'd4);
      tick();
    end

    // Redirect while full.
    id_ready = 1'b0;
    repeat (4) tick();
    start_redirect(32'hbfc0_0100);
    #1;
    check("t3_gate", 32'(if_valid), 32'd0);
    check("t3_en", 32'(inst_sram_en), 32'd1);
    check("t3_addr", 32'(inst_sram_addr), 32'h40);
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    #1;
    check("t3_bubble", 32'(if_valid), 32'd0);
    tick(); #1;
    check("t3_first_valid", 32'(if_valid), 32'd1);
    check("t3_first_pc", if_pc, 32'hbfc0_0100);
    repeat (3) tick();

    // Redirect with id_ready high, then back-to-back A/B.
    start_redirect(32'hbfc0_0200);
    #1;
    check("t4_gate", 32'(if_valid), 32'd0);
    tick();
    start_redirect(32'hbfc0_0300);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4_bubble", 32'(if_valid), 32'd0);
    tick(); #1;
    check("t4_b_pc", if_pc, 32'hbfc0_0300);
    repeat (3) tick();

    // Misaligned redirect.
    start_redirect(32'hbfc0_0102);
    tick();
    redirect_valid = 1'b0;
    tick(); #1;
    check("t5_pc", if_pc, 32'hbfc0_0102);
    check("t5_adel", 32'(if_adel), 32'd1);
    check("t5_inst", if_inst, ram_word(18'h40));
    repeat (3) tick();

    // PC wrap-around.
    start_redirect(32'hffff_fff8);
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();

    // Random backpressure and redirects.
    for (int c = 0; c < 200; c++) begin
      tick();
      redirect_valid = 1'b0;
      id_ready       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) begin
        rnd_pc = RST_PC + 32'($urandom_range(0, 1023)) * 32'd4 + 32'($urandom_range(0, 3) == 0) * 32'd2;
        start_redirect(rnd_pc);
      end
    end
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    repeat (4) tick();

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #2;
    check("t6_en_before", 32'(inst_sram_en), 32'd1);
    resetn = 1'b0;
    #1;
    check("t6_en_async", 32'(inst_sram_en), 32'd0);
    check("t6_valid_async", 32'(if_valid), 32'd0);
    check("t6_pc_async", if_pc, 32'd0);
    sb_restart(RST_PC);
    tick(); tick();
    resetn = 1'b1;
    #1;
    check("t6_addr", 32'(inst_sram_addr), 32'h0);
    tick(); tick(); #1;
    check("t6_pc", if_pc, RST_PC);
    repeat (4) tick();

    check("pops_seen", 32'(n_pop > 60), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
